// File: rtl/instr_mem_loader.sv
// Byte-stream instruction-memory loader: packs big-endian bytes into words and writes them sequentially.
// Optional `LOADER_CHECKSUM_EN adds a per-session modulo-2^M sum of written words on port checksum.
module instr_mem_loader #(
    parameter int N = 8,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N:0]   num_words,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic         wr_en,
    output logic [M-1:0] wr_addr,
    output logic [M-1:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic [N:0]   words_written
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [M-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [N:0] MAX_WORDS = {1'b1, {N{1'b0}}};

    // Saturate the requested length to the memory depth so addresses never wrap.
    function automatic logic [N:0] clamp_count(input logic [N:0] n);
        return (n > MAX_WORDS) ? MAX_WORDS : n;
    endfunction

    state_t     state;
    state_t     state_next;
    logic [N:0] count_lat;
    logic [N:0] count_in;
    logic [1:0] byte_cnt;
    logic [M-1:0] word;
    logic       last_word;

    assign count_in  = clamp_count(num_words);
    assign last_word = ((words_written + {{N{1'b0}}, 1'b1}) == count_lat);
    assign wr_data   = word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // wr_en and byte_ready are gated by rst so a reset cycle can neither write nor accept a byte.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (count_in == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                byte_ready = ~rst;
                if (byte_valid && (byte_cnt == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en      = ~rst;
                state_next = last_word ? DONE : RECV;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_lat     <= '0;
            byte_cnt      <= '0;
            word          <= '0;
            wr_addr       <= '0;
            words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_lat     <= count_in;
                        byte_cnt      <= '0;
                        word          <= '0;
                        wr_addr       <= '0;
                        words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum      <= '0;
`endif
                    end
                end
                RECV: begin
                    // Shifting in four bytes leaves the first byte in [31:24].
                    if (byte_valid) begin
                        if (byte_cnt == 2'd0) begin
                            word <= {{(M-8){1'b0}}, byte_in};
                        end else begin
                            word <= {word[M-9:0], byte_in};
                        end
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    wr_addr       <= wr_addr + M'(4);
                    words_written <= words_written + {{N{1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
                    checksum      <= checksum + word;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: default-size instance plus an N=2 instance for clamping.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [8:0]  num_words = '0;
    logic [2:0]  num_words2 = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;

    logic        byte_ready, wr_en, busy, done;
    logic [31:0] wr_addr, wr_data;
    logic [8:0]  words_written;
    logic        byte_ready2, wr_en2, busy2, done2;
    logic [31:0] wr_addr2, wr_data2;
    logic [2:0]  words_written2;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum, checksum2;
`endif

    int errors = 0;
    int checks = 0;
    int sel = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t q1[$];
    wr_t q2[$];

    logic rdy_sel, done_sel, wr_en_sel;
    assign rdy_sel   = (sel != 0) ? byte_ready2 : byte_ready;
    assign done_sel  = (sel != 0) ? done2 : done;
    assign wr_en_sel = (sel != 0) ? wr_en2 : wr_en;

    always #5 clk = ~clk;

    instr_mem_loader #(.N(8), .M(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .words_written(words_written)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    instr_mem_loader #(.N(2), .M(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_words(num_words2),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .done(done2), .words_written(words_written2)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum2)
`endif
    );

    // Scoreboards: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL write1_unexpected addr=%h data=%h required=no write", wr_addr, wr_data);
            end else begin
                e = q1.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write1 addr=%h data=%h required addr=%h data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (wr_en2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL write2_unexpected addr=%h data=%h required=no write", wr_addr2, wr_data2);
            end else begin
                e = q2.pop_front();
                if (wr_addr2 !== e.addr || wr_data2 !== e.data) begin
                    errors++;
                    $display("FAIL write2 addr=%h data=%h required addr=%h data=%h",
                             wr_addr2, wr_data2, e.addr, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (rdy_sel !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_handshake ready=%b required=1 within 50 cycles", rdy_sel);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], 0);
    endtask

    task automatic start_session(input int s, input int nw);
        if (s == 0) begin
            start     = 1'b1;
            num_words = 9'(nw);
        end else begin
            start2     = 1'b1;
            num_words2 = 3'(nw);
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_sel === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_en, byte_ready, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl wr_en,ready,busy,done=%b required=0000", {wr_en, byte_ready, busy, done});
        end
        checks++;
        if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h data=%h required 0/0", wr_addr, wr_data);
        end
        checks++;
        if (words_written !== 9'd0) begin
            errors++;
            $display("FAIL reset_count words_written=%0d required=0", words_written);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_words;
        bit ok;
        sel = 0;
        q1.push_back({32'h0, 32'h20080005});
        q1.push_back({32'h4, 32'h8C090004});
        start_session(0, 2);
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL two_words_recv busy=%b ready=%b required 1/1", busy, byte_ready);
        end
        send_word(32'h20080005, 0);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL two_words_latency wr_en=%b required=1", wr_en);
        end
        send_word(32'h8C090004, 0);
        wait_done(ok);
        checks++;
        if (!ok || words_written !== 9'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL two_words_done seen=%0d words=%0d busy=%b required 1/2/1", ok, words_written, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL two_words_idle busy=%b done=%b required 0/0", busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (words_written !== 9'd2 || q1.size() != 0) begin
            errors++;
            $display("FAIL two_words_hold words=%0d pending=%0d required 2/0", words_written, q1.size());
        end
    endtask

    task automatic test_zero_words;
        sel = 0;
        start_session(0, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || words_written !== 9'd0) begin
            errors++;
            $display("FAIL zero_done done=%b busy=%b words=%0d required 1/1/0", done, busy, words_written);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_clamp;
        bit ok;
        sel = 1;
        for (int i = 0; i < 4; i++) q2.push_back({32'(4 * i), 32'h10203040 + 32'(i * 32'h01010101)});
        start_session(1, 7);
        for (int i = 0; i < 4; i++) send_word(32'h10203040 + 32'(i * 32'h01010101), 0);
        wait_done(ok);
        checks++;
        if (!ok || words_written2 !== 3'd4 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done seen=%0d words=%0d busy=%b required 1/4/1", ok, words_written2, busy2);
        end
        @(posedge clk);
        #1;
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        checks++;
        if (byte_ready2 !== 1'b0 || q2.size() != 0 || words_written2 !== 3'd4) begin
            errors++;
            $display("FAIL clamp_idle ready=%b pending=%0d words=%0d required 0/0/4",
                     byte_ready2, q2.size(), words_written2);
        end
        sel = 0;
    endtask

    task automatic test_gaps_and_restart;
        bit ok;
        sel = 0;
        q1.push_back({32'h0, 32'hA1B2C3D4});
        start_session(0, 1);
        send_byte(8'hA1, 1);
        send_byte(8'hB2, 1);
        start_session(0, 5);
        send_byte(8'hC3, 1);
        send_byte(8'hD4, 0);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL gaps_latency wr_en=%b required=1", wr_en);
        end
        wait_done(ok);
        checks++;
        if (!ok || words_written !== 9'd1 || q1.size() != 0) begin
            errors++;
            $display("FAIL gaps_done seen=%0d words=%0d pending=%0d required 1/1/0", ok, words_written, q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        sel = 0;
        start_session(0, 2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({wr_en, byte_ready, busy, done} !== 4'b0000 || wr_addr !== 32'h0 ||
            wr_data !== 32'h0 || words_written !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid flags=%b addr=%h data=%h words=%0d required 0000/0/0/0",
                     {wr_en, byte_ready, busy, done}, wr_addr, wr_data, words_written);
        end
        rst = 1'b0;
        q1.push_back({32'h0, 32'hCAFEBABE});
        start_session(0, 1);
        send_word(32'hCAFEBABE, 0);
        wait_done(ok);
        checks++;
        if (!ok || q1.size() != 0 || words_written !== 9'd1) begin
            errors++;
            $display("FAIL reset_mid_resume seen=%0d pending=%0d words=%0d required 1/0/1", ok, q1.size(), words_written);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_write;
        sel = 0;
        start_session(0, 1);
        send_word(32'hDEADBEEF, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_write wr_en=%b required=0", wr_en);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || words_written !== 9'd0 || wr_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_after busy=%b words=%0d addr=%h required 0/0/0", busy, words_written, wr_addr);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        bit ok;
        sel = 0;
        q1.push_back({32'h0, 32'hFFFFFFFF});
        q1.push_back({32'h4, 32'h00000002});
        start_session(0, 2);
        send_word(32'hFFFFFFFF, 0);
        send_word(32'h00000002, 0);
        wait_done(ok);
        checks++;
        if (!ok || checksum !== 32'h00000001) begin
            errors++;
            $display("FAIL checksum seen=%0d value=%h required 1/00000001", ok, checksum);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_zero_words();
        test_clamp();
        test_gaps_and_restart();
        test_reset_mid();
        test_reset_in_write();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL final_pending q1=%0d q2=%0d required 0/0", q1.size(), q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
